// File: rtl/vdp_pkg.sv
// vdp_pkg: shared encodings for the VDP CPU port.
// Display modes, register bit positions, control latch states and status bits.
package vdp_pkg;

  // Display mode encodings presented to the video block
  localparam logic [1:0] MODE_TEXT = 2'd0;
  localparam logic [1:0] MODE_G1   = 2'd1;
  localparam logic [1:0] MODE_G2   = 2'd2;
  localparam logic [1:0] MODE_MC   = 2'd3;

  // Register bit positions
  localparam int R1_M1_BIT    = 4;
  localparam int R1_M2_BIT    = 3;
  localparam int R0_M3_BIT    = 1;
  localparam int R1_BLANK_BIT = 6;
  localparam int R1_IE_BIT    = 5;

  // Status register: vblank flag position
  localparam int STAT_F = 7;

  // Control port two-byte sequence tracker
  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } ctl_state_t;

  // Mode priority: M1 beats M2 beats M3; none set selects graphics 1
  function automatic logic [1:0] decode_mode(input logic m1, input logic m2, input logic m3);
    if (m1)      return MODE_TEXT;
    else if (m2) return MODE_G2;
    else if (m3) return MODE_MC;
    else         return MODE_G1;
  endfunction

endpackage

// File: rtl/vdp_edge_sync.sv
// vdp_edge_sync: falling-edge pulse generator for the active-low vblank line.
// Define VDP_VBLANK_SYNC_EN to insert a 2-flop synchronizer in front of the
// edge detector when the video clock is asynchronous to clk.
module vdp_edge_sync (
  input  logic clk,
  input  logic n_reset,
  input  logic sig_n,
  output logic fall
);

  logic sampled;

`ifdef VDP_VBLANK_SYNC_EN
  logic [1:0] sync_reg;

  // Two-stage synchronizer; idles high so reset release is not seen as an edge
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) sync_reg <= 2'b11;
    else          sync_reg <= {sync_reg[0], sig_n};
  end

  assign sampled = sync_reg[1];
`else
  assign sampled = sig_n;
`endif

  logic prev_reg;

  // Previous sample of the line, used to spot a high-to-low transition
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) prev_reg <= 1'b1;
    else          prev_reg <= sampled;
  end

  assign fall = prev_reg & ~sampled;

endmodule

// File: rtl/vdp_port.sv
// vdp_port: CPU-facing VDP front end. Decodes data/control port accesses,
// holds R0-R7, drives VRAM port A and owns the vblank flag and CPU interrupt.
// Optional VDP_VBLANK_SYNC_EN synchronizes vid_n_int before edge detection.
module vdp_port
  import vdp_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic              cpu_port,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic [ADDR_W-1:0] vga_addr,
  output logic [7:0]        vga_din,
  output logic              vga_wr,
  output logic              vga_rd,
  input  logic [7:0]        vga_dout,
  input  logic              vid_n_int,
  output logic              n_int,
  output logic [1:0]        mode,
  output logic              video_on,
  output logic [13:0]       name_table_addr,
  output logic [13:0]       font_addr,
  output logic [13:0]       color_table_addr,
  output logic [13:0]       sprite_attr_addr,
  output logic [13:0]       sprite_pattern_table_addr,
  output logic [3:0]        text_color,
  output logic [3:0]        back_color
);

  ctl_state_t        state_reg;
  logic [7:0]        latch_reg;
  logic [7:0]        vdp_reg [8];
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        buffer_reg;
  logic [7:0]        cpu_dout_reg;
  logic              vga_wr_reg;
  logic              vga_rd_reg;
  logic [ADDR_W-1:0] vga_addr_reg;
  logic [7:0]        vga_din_reg;
  logic              capture_reg;
  logic              f_reg;
  logic              vblank_fall;

  // A simultaneous write and read strobe is treated as a write only
  logic wr_take;
  logic rd_take;
  assign wr_take = cpu_wr;
  assign rd_take = cpu_rd & ~cpu_wr;

  // Second control byte: address formed from low 6 bits plus latched byte
  logic [ADDR_W-1:0] ctl_addr;
  assign ctl_addr = ADDR_W'({cpu_din[5:0], latch_reg});

  logic reg_we;
  assign reg_we = wr_take & cpu_port & (state_reg == SECOND) & cpu_din[7];

  logic ctl_rd;
  assign ctl_rd = rd_take & cpu_port;

  vdp_edge_sync u_edge_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .sig_n   (vid_n_int),
    .fall    (vblank_fall)
  );

  // Port sequencing: control latch FSM, VRAM address pointer, strobes and read-ahead buffer
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg    <= FIRST;
      latch_reg    <= 8'h00;
      addr_reg     <= '0;
      buffer_reg   <= 8'h00;
      cpu_dout_reg <= 8'h00;
      vga_wr_reg   <= 1'b0;
      vga_rd_reg   <= 1'b0;
      vga_addr_reg <= '0;
      vga_din_reg  <= 8'h00;
      capture_reg  <= 1'b0;
    end else begin
      vga_wr_reg  <= 1'b0;
      vga_rd_reg  <= 1'b0;
      capture_reg <= vga_rd_reg;
      // VRAM data arrives the cycle after the read strobe
      if (capture_reg) buffer_reg <= vga_dout;

      if (wr_take) begin
        if (!cpu_port) begin
          // Data write; placed after the capture so write data wins the buffer
          state_reg    <= FIRST;
          vga_wr_reg   <= 1'b1;
          vga_addr_reg <= addr_reg;
          vga_din_reg  <= cpu_din;
          buffer_reg   <= cpu_din;
          addr_reg     <= addr_reg + ADDR_W'(1);
        end else if (state_reg == FIRST) begin
          latch_reg <= cpu_din;
          state_reg <= SECOND;
        end else begin
          state_reg <= FIRST;
          if (!cpu_din[7]) begin
            addr_reg <= ctl_addr;
            if (!cpu_din[6]) begin
              // Read setup: prefetch the first byte right away
              vga_rd_reg   <= 1'b1;
              vga_addr_reg <= ctl_addr;
              addr_reg     <= ctl_addr + ADDR_W'(1);
            end
          end
        end
      end else if (rd_take) begin
        state_reg <= FIRST;
        if (!cpu_port) begin
          cpu_dout_reg <= buffer_reg;
          vga_rd_reg   <= 1'b1;
          vga_addr_reg <= addr_reg;
          addr_reg     <= addr_reg + ADDR_W'(1);
        end else begin
          cpu_dout_reg <= {f_reg, 7'b0};
        end
      end
    end
  end

  // Register file R0-R7, written from the latched byte on a register-write command
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < 8; i++) vdp_reg[i] <= 8'h00;
    end else if (reg_we) begin
      vdp_reg[cpu_din[2:0]] <= latch_reg;
    end
  end

  // Vblank flag: set by the vblank edge, cleared by a status read, set wins a tie
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)         f_reg <= 1'b0;
    else if (vblank_fall) f_reg <= 1'b1;
    else if (ctl_rd)      f_reg <= 1'b0;
  end

  assign cpu_dout = cpu_dout_reg;
  assign vga_addr = vga_addr_reg;
  assign vga_din  = vga_din_reg;
  assign vga_wr   = vga_wr_reg;
  assign vga_rd   = vga_rd_reg;

  assign n_int    = ~(f_reg & vdp_reg[1][R1_IE_BIT]);
  assign mode     = decode_mode(vdp_reg[1][R1_M1_BIT], vdp_reg[1][R1_M2_BIT], vdp_reg[0][R0_M3_BIT]);
  assign video_on = vdp_reg[1][R1_BLANK_BIT];

  assign name_table_addr           = {vdp_reg[2][3:0], 10'b0};
  assign color_table_addr          = {vdp_reg[3], 6'b0};
  assign font_addr                 = {vdp_reg[4][2:0], 11'b0};
  assign sprite_attr_addr          = {vdp_reg[5][6:0], 7'b0};
  assign sprite_pattern_table_addr = {vdp_reg[6][2:0], 11'b0};
  assign text_color                = vdp_reg[7][7:4];
  assign back_color                = vdp_reg[7][3:0];

endmodule

// File: tb/tb_vdp_port.sv
// tb_vdp_port: scoreboard bench for vdp_port. Stimulus pushes expected VRAM
// strobes and CPU read data into a queue; a forked monitor pops and compares.
module tb_vdp_port;

  localparam int K_DOUT = 0;
  localparam int K_WR   = 1;
  localparam int K_RD   = 2;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic        cpu_port = 1'b0;
  logic [7:0]  cpu_din = 8'h00;
  logic [7:0]  cpu_dout;
  logic [13:0] vga_addr;
  logic [7:0]  vga_din;
  logic        vga_wr;
  logic        vga_rd;
  logic [7:0]  vga_dout = 8'h00;
  logic        vid_n_int = 1'b1;
  logic        n_int;
  logic [1:0]  mode;
  logic        video_on;
  logic [13:0] name_table_addr;
  logic [13:0] font_addr;
  logic [13:0] color_table_addr;
  logic [13:0] sprite_attr_addr;
  logic [13:0] sprite_pattern_table_addr;
  logic [3:0]  text_color;
  logic [3:0]  back_color;

  typedef struct {
    int          kind;
    logic [13:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  always #5 clk = ~clk;

  vdp_port #(.ADDR_W(14)) dut (
    .clk                       (clk),
    .n_reset                   (n_reset),
    .cpu_wr                    (cpu_wr),
    .cpu_rd                    (cpu_rd),
    .cpu_port                  (cpu_port),
    .cpu_din                   (cpu_din),
    .cpu_dout                  (cpu_dout),
    .vga_addr                  (vga_addr),
    .vga_din                   (vga_din),
    .vga_wr                    (vga_wr),
    .vga_rd                    (vga_rd),
    .vga_dout                  (vga_dout),
    .vid_n_int                 (vid_n_int),
    .n_int                     (n_int),
    .mode                      (mode),
    .video_on                  (video_on),
    .name_table_addr           (name_table_addr),
    .font_addr                 (font_addr),
    .color_table_addr          (color_table_addr),
    .sprite_attr_addr          (sprite_attr_addr),
    .sprite_pattern_table_addr (sprite_pattern_table_addr),
    .text_color                (text_color),
    .back_color                (back_color)
  );

  // VRAM model: fixed contents, read data valid the cycle after vga_rd
  always @(posedge clk) begin
    if (vga_rd) begin
      case (vga_addr)
        14'h0100: vga_dout <= 8'h12;
        14'h0101: vga_dout <= 8'h34;
        default:  vga_dout <= 8'h00;
      endcase
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic push(input int k, input logic [13:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic take(input int k, input logic [13:0] a, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected event: kind %0d addr 0x%0h data 0x%0h, expected none", k, a, d);
    end else begin
      e = exp_q.pop_front();
      check("event kind", 16'(k), 16'(e.kind));
      if (k != K_DOUT) check("vga_addr", 16'(a), 16'(e.addr));
      if (k != K_RD)   check(k == K_WR ? "vga_din" : "cpu_dout", 16'(d), 16'(e.data));
    end
  endtask

  // Monitor: a read strobe seen at a rising edge yields cpu_dout by the next falling edge
  task automatic monitor();
    bit rd_now;
    forever begin
      @(posedge clk);
      rd_now = n_reset && cpu_rd && !cpu_wr;
      @(negedge clk);
      if (rd_now) take(K_DOUT, 14'h0, cpu_dout);
      if (vga_wr) take(K_WR, vga_addr, vga_din);
      if (vga_rd) take(K_RD, vga_addr, 8'h00);
    end
  endtask

  // One strobe, then idle so consecutive accesses are 3 cycles apart
  task automatic strobe(input bit port, input bit wr, input bit rd, input logic [7:0] d);
    @(negedge clk);
    cpu_port = port;
    cpu_wr   = wr;
    cpu_rd   = rd;
    cpu_din  = d;
    @(negedge clk);
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic ctl(input logic [7:0] d);
    strobe(1'b1, 1'b1, 1'b0, d);
  endtask

  task automatic wreg(input int n, input logic [7:0] v);
    logic [7:0] cmd;
    cmd = 8'h80 | 8'(n);
    ctl(v);
    ctl(cmd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] r0v [5];
    logic [7:0] r1v [5];
    logic [1:0] expm[5];
    r0v  = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h02};
    r1v  = '{8'h10, 8'h08, 8'h18, 8'h00, 8'h08};
    expm = '{2'd0,  2'd2,  2'd0,  2'd3,  2'd2};

    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);

    // Reset state
    check("reset mode", 16'(mode), 16'd1);
    check("reset video_on", 16'(video_on), 16'd0);
    check("reset n_int", 16'(n_int), 16'd1);
    check("reset cpu_dout", 16'(cpu_dout), 16'h00);
    check("reset vga_wr", 16'(vga_wr), 16'd0);
    check("reset vga_rd", 16'(vga_rd), 16'd0);
    check("reset vga_addr", 16'(vga_addr), 16'h0);
    check("reset name_table_addr", 16'(name_table_addr), 16'h0);
    check("reset colors", 16'({text_color, back_color}), 16'h00);

    // Colour register
    wreg(7, 8'h07);
    check("text_color R7=07", 16'(text_color), 16'h0);
    check("back_color R7=07", 16'(back_color), 16'h7);
    wreg(7, 8'hF5);
    check("text_color R7=F5", 16'(text_color), 16'hF);
    check("back_color R7=F5", 16'(back_color), 16'h5);

    // Write setup 0x1800 and two data writes
    ctl(8'h00);
    ctl(8'h58);
    push(K_WR, 14'h1800, 8'hAA);
    strobe(1'b0, 1'b1, 1'b0, 8'hAA);
    push(K_WR, 14'h1801, 8'hBB);
    strobe(1'b0, 1'b1, 1'b0, 8'hBB);

    // Read setup 0x0100: prefetch, then two reads with follow-on prefetches
    ctl(8'h00);
    push(K_RD, 14'h0100, 8'h00);
    ctl(8'h01);
    push(K_DOUT, 14'h0, 8'h12);
    push(K_RD, 14'h0101, 8'h00);
    strobe(1'b0, 1'b0, 1'b1, 8'h00);
    push(K_DOUT, 14'h0, 8'h34);
    push(K_RD, 14'h0102, 8'h00);
    strobe(1'b0, 1'b0, 1'b1, 8'h00);

    // Address wrap 0x3FFF -> 0x0000; second write also raises cpu_rd (ignored)
    ctl(8'hFF);
    ctl(8'h7F);
    push(K_WR, 14'h3FFF, 8'h11);
    strobe(1'b0, 1'b1, 1'b0, 8'h11);
    push(K_WR, 14'h0000, 8'h22);
    strobe(1'b0, 1'b1, 1'b1, 8'h22);
    // Buffer holds the last written byte; read returns it and prefetches 0x0001
    push(K_DOUT, 14'h0, 8'h22);
    push(K_RD, 14'h0001, 8'h00);
    strobe(1'b0, 1'b0, 1'b1, 8'h00);

    // Table base addresses
    wreg(2, 8'h0F);
    wreg(3, 8'hFF);
    wreg(4, 8'h07);
    wreg(5, 8'h7F);
    wreg(6, 8'h05);
    check("name_table_addr", 16'(name_table_addr), 16'h3C00);
    check("color_table_addr", 16'(color_table_addr), 16'h3FC0);
    check("font_addr", 16'(font_addr), 16'h3800);
    check("sprite_attr_addr", 16'(sprite_attr_addr), 16'h3F80);
    check("sprite_pattern_table_addr", 16'(sprite_pattern_table_addr), 16'h2800);

    // Mode priority table
    for (int i = 0; i < 5; i++) begin
      wreg(0, r0v[i]);
      wreg(1, r1v[i]);
      check("mode", 16'(mode), 16'(expm[i]));
    end
    wreg(0, 8'h00);

    // Vblank flag and interrupt
    wreg(1, 8'h60);
    check("video_on R1=60", 16'(video_on), 16'd1);
    check("n_int before vblank", 16'(n_int), 16'd1);
    @(negedge clk);
    vid_n_int = 1'b0;
    @(negedge clk);
    vid_n_int = 1'b1;
    repeat (4) @(negedge clk);
    check("n_int after vblank", 16'(n_int), 16'd0);
    push(K_DOUT, 14'h0, 8'h80);
    strobe(1'b1, 1'b0, 1'b1, 8'h00);
    check("n_int after status read", 16'(n_int), 16'd1);
    push(K_DOUT, 14'h0, 8'h00);
    strobe(1'b1, 1'b0, 1'b1, 8'h00);

    // Status read resets the control latch: stale 0x34 never used
    ctl(8'h34);
    push(K_DOUT, 14'h0, 8'h00);
    strobe(1'b1, 1'b0, 1'b1, 8'h00);
    ctl(8'h05);
    ctl(8'h81);
    check("mode R1=05", 16'(mode), 16'd1);
    check("video_on R1=05", 16'(video_on), 16'd0);
    check("font_addr kept", 16'(font_addr), 16'h3800);
    check("back_color kept", 16'(back_color), 16'h5);

    repeat (5) @(negedge clk);
    check("scoreboard drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
